// File: rtl/if_stage_queue_if.sv
// Bundles the instruction-fetch stage's execute, memory and decode signals.
// master: the fetch stage. slave: the surrounding pipeline/memory.
interface if_stage_queue_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) ();
  logic             PCSrcE;
  logic [XLEN-1:0]  PCTargetE;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic             imem_valid;
  logic             if_id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  if_id_ir;
  logic [XLEN-1:0]  if_id_pc;
  logic [XLEN-1:0]  if_id_pc1;
  logic [CNT_W-1:0] if_count;

  modport master (
    input  PCSrcE, PCTargetE, imem_rdata, imem_valid, id_ready,
    output imem_addr, if_id_valid, if_id_ir, if_id_pc, if_id_pc1, if_count
  );

  modport slave (
    output PCSrcE, PCTargetE, imem_rdata, imem_valid, id_ready,
    input  imem_addr, if_id_valid, if_id_ir, if_id_pc, if_id_pc1, if_count
  );
endinterface

// File: rtl/if_stage_queue.sv
// Instruction-fetch stage with a small prefetch queue.
// Owns the PC, drives a combinational imem read port, buffers fetched
// {ir, pc, pc+inc} triples so decode can stall while fetch continues.
// Redirects from execute reload the PC and flush the queue.
// Optional feature macro: IF_PERF_CNT_EN (adds perf_fetched/perf_redirects).
module if_stage_queue #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 2,
  parameter int          PC_INC   = 1,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  if_stage_queue_if.master        bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_redirects
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] INC_C   = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_PC);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] ir_q  [DEPTH];
  logic [XLEN-1:0] ir_d  [DEPTH];
  logic [XLEN-1:0] epc_q [DEPTH];
  logic [XLEN-1:0] epc_d [DEPTH];
  logic [XLEN-1:0] epc1_q[DEPTH];
  logic [XLEN-1:0] epc1_d[DEPTH];

  logic            q_valid;
  logic            deq;
  logic            fetch;
  logic [XLEN-1:0] pc_next_seq;

  assign q_valid     = (count_q != '0);
  assign deq         = q_valid && bus.id_ready;
  // Fetch may proceed when full only if the head leaves this same cycle.
  assign fetch       = bus.imem_valid && !bus.PCSrcE &&
                       ((count_q < DEPTH_C) || deq);
  assign pc_next_seq = pc_q + INC_C;

  // PC, pointer and occupancy next-state; redirect flushes everything.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.PCSrcE) begin
      pc_d    = bus.PCTargetE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch) begin
        pc_d   = pc_next_seq;
        tail_d = tail_q + 1'b1;
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(fetch) - CW'(deq);
    end
  end

  // Queue storage next-state: write the fetched triple at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ir_d[i]   = ir_q[i];
      epc_d[i]  = epc_q[i];
      epc1_d[i] = epc1_q[i];
      if (fetch && (tail_q == PW'(i))) begin
        ir_d[i]   = bus.imem_rdata;
        epc_d[i]  = pc_q;
        epc1_d[i] = pc_next_seq;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RST_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]   <= '0;
        epc_q[i]  <= '0;
        epc1_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]   <= ir_d[i];
        epc_q[i]  <= epc_d[i];
        epc1_q[i] <= epc1_d[i];
      end
    end
  end

  // Head presentation; zeroed while the queue is empty.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.if_id_valid = q_valid;
    bus.if_count    = count_q;
    bus.if_id_ir    = '0;
    bus.if_id_pc    = '0;
    bus.if_id_pc1   = '0;
    if (q_valid) begin
      bus.if_id_ir  = ir_q[head_q];
      bus.if_id_pc  = epc_q[head_q];
      bus.if_id_pc1 = epc1_q[head_q];
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  // Event counters; free-running, wrap naturally.
  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(fetch);
    perf_redirects_d = perf_redirects_q + 32'(bus.PCSrcE);
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
